// File: rtl/timeout_arbiter_pkg.sv
// timeout_arbiter_pkg
//   Shared definitions for the chess-clock blocks.
//   - ST_RUN / ST_DONE : arbiter state encoding
//   - QUAL_W           : width of a per-channel qualification counter
//   - loser_width()    : width of the LOSER index, max(1, clog2(n_ch))
package timeout_arbiter_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // GUARD may be as large as 255, so eight bits always hold the count
  localparam int QUAL_W = 8;

  function automatic int loser_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/timeout_arbiter_overflow_qualifier.sv
// overflow_qualifier
//   One channel of the timeout arbiter: a saturating count of consecutive
//   CE-qualified cycles with OVERFLOW high, and a sticky flag set on the
//   edge where that count reaches GUARD.
//   Ports:
//     clk      in  system clock, rising edge
//     clr      in  synchronous active-high reset
//     ce       in  clock enable for the counter
//     overflow in  timer-expired level for this channel
//     freeze   in  game over: counter and flag hold
//     flag     out sticky flagged status (registered)
//     set_now  out flag is being set on the coming edge
module overflow_qualifier #(
  parameter int GUARD = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic ce,
  input  logic overflow,
  input  logic freeze,
  output logic flag,
  output logic set_now
);
  import timeout_arbiter_pkg::*;

  localparam logic [QUAL_W-1:0] GUARD_CNT = QUAL_W'(GUARD);

  logic [QUAL_W-1:0] count;

  // The sample that moves the counter from GUARD-1 to GUARD qualifies the
  // channel; a channel already flagged never reports a new set.
  assign set_now = ~freeze & ce & overflow & ~flag & (count == GUARD_CNT - 1'b1);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (!freeze && ce) begin
      if (overflow) begin
        if (count != GUARD_CNT) count <= count + 1'b1;
      end else begin
        count <= '0;
      end
      if (set_now) flag <= 1'b1;
    end
  end

endmodule

// File: rtl/timeout_arbiter.sv
// timeout_arbiter
//   Watches N_CH player timers and decides when the game is over.
//   Each channel is qualified by an overflow_qualifier; this level holds
//   the RUN/DONE state machine, the lowest-index priority encoder that
//   picks LOSER and the popcount used by elimination mode.
//   Parameters: N_CH (2..16), GUARD (1..255), MODE (0 first flag, 1 elimination)
//   Ports:
//     CLK      in  system clock, rising edge
//     CLR      in  synchronous active-high reset
//     CE       in  clock enable for qualification counting
//     OVERFLOW in  per-channel timer-expired levels
//     END      out game over, sticky until CLR
//     FLAGS    out sticky per-channel flagged status
//     LOSER    out index of the first channel to flag
//     EVENT    out one-cycle pulse after any new flag
module timeout_arbiter import timeout_arbiter_pkg::*; #(
  parameter int N_CH  = 2,
  parameter int GUARD = 1,
  parameter int MODE  = 0
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic                          CE,
  input  logic [N_CH-1:0]               OVERFLOW,
  output logic                          END,
  output logic [N_CH-1:0]               FLAGS,
  output logic [loser_width(N_CH)-1:0]  LOSER,
  output logic                          EVENT
);

  localparam int LW = loser_width(N_CH);

  logic [0:0]      state;
  logic            freeze;
  logic [N_CH-1:0] set_vec;
  logic [N_CH-1:0] flags_next;
  logic [LW-1:0]   first_idx;
  logic [4:0]      pop_next;
  logic            end_next;

  assign freeze     = (state == ST_DONE);
  assign flags_next = FLAGS | set_vec;
  assign END        = (state == ST_DONE);

  for (genvar g = 0; g < N_CH; g++) begin : g_qual
    overflow_qualifier #(.GUARD(GUARD)) u_qual (
      .clk      (CLK),
      .clr      (CLR),
      .ce       (CE),
      .overflow (OVERFLOW[g]),
      .freeze   (freeze),
      .flag     (FLAGS[g]),
      .set_now  (set_vec[g])
    );
  end

  // Lowest index wins when several channels qualify together
  always_comb begin
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (set_vec[i]) first_idx = LW'(i);
    end
  end

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_next = pop_next + 5'(flags_next[i]);
    end
  end

  // The end decision looks at the flags as they will be after this edge,
  // so END rises together with the deciding flag
  assign end_next = (MODE == 0) ? (|flags_next) : (pop_next >= 5'(N_CH - 1));

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= ST_RUN;
      LOSER <= '0;
      EVENT <= 1'b0;
    end else begin
      EVENT <= |set_vec;
      if (FLAGS == '0 && |set_vec) LOSER <= first_idx;
      if (state == ST_RUN && end_next) state <= ST_DONE;
    end
  end

endmodule

// File: doc/timeout_arbiter.md
TIMEOUT_ARBITER -- requirements
Module: timeout_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, meaning the number of player timer channels; legal range 2..16.
REQ-002 The block SHALL have parameter GUARD, default 1, meaning the number of consecutive CE-qualified cycles OVERFLOW[i] must be high to count as a flag; legal range 1..255.
REQ-003 The block SHALL have parameter MODE, default 0, meaning 0 = game ends on the first flag and 1 = elimination, where the game ends when N_CH-1 channels have flagged.
REQ-004 The block SHALL have port CLK  input  1  system clock, rising edge active.
REQ-005 The block SHALL have port CLR  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port CE  input  1  clock enable; qualification counting advances only when CE=1.
REQ-007 The block SHALL have port OVERFLOW  input  N_CH  per-channel timer-expired level from the player counters.
REQ-008 The block SHALL have port END  output  1  game over, registered and sticky until CLR.
REQ-009 The block SHALL have port FLAGS  output  N_CH  sticky per-channel flagged status.
REQ-010 The block SHALL have port LOSER  output  max(1,clog2(N_CH))  index of the first channel to flag.
REQ-011 The block SHALL have port EVENT  output  1  one-cycle pulse whenever at least one new flag is set.

Function
REQ-012 Per channel, the block SHALL run a qualification counter: CE=1 and OVERFLOW[i]=1 increments it, saturating at GUARD.
REQ-013 Per channel, CE=1 and OVERFLOW[i]=0 SHALL clear the qualification counter.
REQ-014 Per channel, CE=0 SHALL hold the qualification counter.
REQ-015 Channel i SHALL qualify on the edge where its counter reaches GUARD; FLAGS[i] goes to 1 on that edge and is visible in the following cycle, so latency from the first qualifying sample is GUARD cycles.
REQ-016 Once set, FLAGS[i] SHALL remain 1 even if OVERFLOW[i] falls, until CLR.
REQ-017 EVENT SHALL be 1 for exactly the cycle after any edge on which one or more FLAGS bits transition 0->1, and 0 otherwise.
REQ-018 The state machine SHALL have two states, RUN and DONE.
REQ-019 RUN->DONE SHALL occur on the edge where the end condition first holds on the next FLAGS value: MODE 0, at least one flag set; MODE 1, popcount >= N_CH-1.
REQ-020 END SHALL be 1 exactly when the state is DONE, so END rises in the same cycle as the deciding FLAGS bit.
REQ-021 LOSER SHALL be captured once, on the edge where the first FLAGS bit is set.
REQ-022 If several channels qualify on the same edge, LOSER SHALL take the lowest index.
REQ-023 LOSER SHALL hold its value until CLR and SHALL be 0 before the first flag.
REQ-024 In DONE, all qualification counters and FLAGS SHALL freeze, EVENT SHALL stay 0, and CE and OVERFLOW SHALL be ignored.
REQ-025 In MODE 1, a flag set while in RUN that does not complete the end condition SHALL pulse EVENT and leave END=0.
REQ-026 Simultaneous qualifications in MODE 1 that jump popcount past N_CH-1 SHALL enter DONE normally and record all of those flags.
REQ-027 With GUARD=1, a single CE=1 cycle with OVERFLOW[i]=1 SHALL qualify channel i.

Reset
REQ-028 CLR=1 on a rising edge SHALL set state RUN, END=0, FLAGS=0, LOSER=0, EVENT=0 and clear all qualification counters, overriding CE and OVERFLOW.
REQ-029 CLR asserted mid-qualification or in DONE SHALL discard all progress; counting restarts from zero on the first non-CLR edge.

Structure
REQ-030 The state encoding and a width helper computing the LOSER width SHALL be placed in a shared package used by the chess-clock blocks.
REQ-031 A single sub-module, overflow_qualifier, SHALL contain one channel's saturating counter and sticky flag, instantiated N_CH times by generate; the top level SHALL hold the FSM, priority encoder and popcount.

Verification
REQ-032 Scenario (N_CH=2, GUARD=1, MODE=0): CLR for 1 cycle, then CE=1 with OVERFLOW=01 for 1 cycle -> the next cycle shows FLAGS=01, END=1, LOSER=0, EVENT=1 for one cycle, and later OVERFLOW=10 leaves FLAGS=01.
REQ-033 Scenario (simultaneous): CE=1 with OVERFLOW=11 in one cycle -> FLAGS=11, LOSER=0, END=1, a single EVENT pulse.
REQ-034 Scenario (GUARD=3, CE toggling 1,0,1,0,1 with OVERFLOW[1]=1) -> FLAGS[1] sets only after the third CE=1 sample, and a glitch to 0 on a CE=1 cycle restarts the count.
REQ-035 Scenario (N_CH=4, MODE=1): channel 2 flags, then channel 0, then channel 3 -> EVENT pulses three times, END rises with the third flag, LOSER=2, FLAGS=1101.
REQ-036 Scenario (reset mid-operation): CLR asserted while in DONE and again two cycles into a GUARD=3 qualification -> all outputs return to 0 and a subsequent qualification needs a full 3 CE cycles.
REQ-037 Scenario (CE=0 held): OVERFLOW=11 for 20 cycles with CE=0 -> FLAGS=00, END=0, EVENT never asserted.
